// File: rtl/serial_subtractor_nbit.sv
// Bit-serial subtractor: diff = a - b - bin (mod 2^WIDTH), bout = borrow-out.
// One full-subtractor cell is reused LSB-first, one bit per clock.
// Ports:
//   clk, rst              clock, async active-high reset
//   in_valid/in_ready     operand handshake (a, b, bin)
//   out_valid/out_ready   result handshake (diff, bout)
//   busy                  high while an operation is shifting or waiting in DONE
module serial_subtractor_nbit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] sa, sb;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic             ai, bi;
    logic             d, bn;
    logic             last;

    // Full-subtractor cell on the current LSBs
    assign ai   = sa[0];
    assign bi   = sb[0];
    assign d    = ai ^ bi ^ borrow;
    assign bn   = (~ai & bi) | (~(ai ^ bi) & borrow);
    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                // Return to IDLE only; new operands are taken next cycle
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        sa     <= a;
                        sb     <= b;
                        borrow <= bin;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    // Result enters at the MSB; after WIDTH shifts bit 0 sits at diff[0]
                    diff   <= {d, diff[WIDTH-1:1]};
                    borrow <= bn;
                    cnt    <= cnt + CW'(1);
                    if (last) bout <= bn;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// Directed and exhaustive checks for serial_subtractor_nbit (WIDTH=4).
// Immediate assertions at every comparison point.
module tb_serial_subtractor_nbit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a, b;
    logic       bin;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] diff;
    logic       bout;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int hs     = 0;
    bit sweep_on = 1'b0;

    serial_subtractor_nbit #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .bin      (bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .bout     (bout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (sweep_on && out_valid && out_ready) hs++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operand set, wait for the result, optionally stall, then accept it
    task automatic do_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic tbin,
                         input int stall, output logic [3:0] rd, output logic rb,
                         output int lat);
        a = ta;
        b = tb_v;
        bin = tbin;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        rd = diff;
        rb = bout;
        repeat (stall) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [3:0] rd, hold_d;
        logic       rb, hold_b;
        logic [4:0] ex;
        int         lat;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        bin = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_diff", diff, 0);
        chk("rst_bout", bout, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // 1: simple subtract, latency WIDTH
        do_op(4'b0011, 4'b0001, 1'b0, 0, rd, rb, lat);
        chk("t1_lat", lat, 4);
        chk("t1_diff", rd, 4'b0010);
        chk("t1_bout", rb, 0);
        chk("t1_idle_ready", in_ready, 1);
        chk("t1_idle_ov", out_valid, 0);

        // 2: wrap-around borrow
        do_op(4'b0000, 4'b0001, 1'b0, 0, rd, rb, lat);
        chk("t2_diff", rd, 4'b1111);
        chk("t2_bout", rb, 1);

        // 3: borrow-in
        do_op(4'b1010, 4'b0101, 1'b1, 0, rd, rb, lat);
        chk("t3a_diff", rd, 4'b0100);
        chk("t3a_bout", rb, 0);
        do_op(4'b1111, 4'b1111, 1'b1, 0, rd, rb, lat);
        chk("t3b_diff", rd, 4'b1111);
        chk("t3b_bout", rb, 1);

        // 4: backpressure with in_valid pulses in DONE
        a = 4'b1001;
        b = 4'b0011;
        bin = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("t4_ov", out_valid, 1);
        hold_d = diff;
        hold_b = bout;
        chk("t4_diff", hold_d, 4'b0110);
        chk("t4_bout", hold_b, 0);
        for (int i = 0; i < 5; i++) begin
            a = 4'(i);
            b = 4'(15 - i);
            bin = 1'(i);
            in_valid = i[0] ? 1'b0 : 1'b1;
            tick();
            chk("t4_hold_ov", out_valid, 1);
            chk("t4_hold_diff", diff, 4'b0110);
            chk("t4_hold_bout", bout, 0);
            chk("t4_hold_ir", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t4_release_ov", out_valid, 0);
        chk("t4_release_ir", in_ready, 1);
        chk("t4_release_busy", busy, 0);

        // 5: async reset mid-SHIFT
        a = 4'b1100;
        b = 4'b0001;
        bin = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("t5_busy_pre", busy, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_ov", out_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_ir", in_ready, 1);
        chk("t5_diff", diff, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        do_op(4'b0111, 4'b0010, 1'b0, 0, rd, rb, lat);
        chk("t5_lat", lat, 4);
        chk("t5_diff_op", rd, 4'b0101);
        chk("t5_bout_op", rb, 0);

        // 6: exhaustive sweep with random stalls
        sweep_on = 1'b1;
        for (int i = 0; i < 512; i++) begin
            logic [3:0] va, vb;
            logic       vbin;
            va = 4'(i >> 5);
            vb = 4'(i >> 1);
            vbin = 1'(i);
            do_op(va, vb, vbin, int'($urandom_range(0, 3)), rd, rb, lat);
            ex = {1'b0, va} - {1'b0, vb} - {4'b0, vbin};
            chk($sformatf("sweep_%0h_%0h_%0d", va, vb, vbin), {rb, rd}, ex);
        end
        sweep_on = 1'b0;
        chk("sweep_handshakes", hs, 512);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
